// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, FSM state encoding and the word-select helper
// for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int ADDR_W      = 16;
  localparam int WORD_W      = 16;
  localparam int LINE_W      = 64;
  localparam int OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WRITEBACK = 2'b01,
    ALLOCATE  = 2'b10
  } state_t;

  // word k of a line lives at bits [16k+15:16k]
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFFSET_BITS-1:0] off);
    return line[off*WORD_W +: WORD_W];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag / valid / dirty / data storage for the data cache.
// Ports:
//   clk, rst_n           clock, async active-low reset (clears valid + dirty only)
//   idx                  line index shared by the read and write ports
//   rd_tag/valid/dirty/line  asynchronous read of line idx
//   ww_en/ww_off/ww_data word write into line idx, marks it dirty
//   lw_en/lw_tag/lw_line line fill into line idx, valid = 1, dirty = 0
//   dirty_clr            clears dirty of line idx after a writeback
module dcache_array import dcache_pkg::*; #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = ADDR_W - INDEX_BITS - OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_BITS-1:0]  idx,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [LINE_W-1:0]      rd_line,
  input  logic                   ww_en,
  input  logic [OFFSET_BITS-1:0] ww_off,
  input  logic [WORD_W-1:0]      ww_data,
  input  logic                   lw_en,
  input  logic [TAG_BITS-1:0]    lw_tag,
  input  logic [LINE_W-1:0]      lw_line,
  input  logic                   dirty_clr
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [TAG_BITS-1:0] tags [LINES];
  logic [LINE_W-1:0]   data [LINES];
  logic [LINES-1:0]    valid, dirty;

  assign rd_tag   = tags[idx];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_line  = data[idx];

  // tag and data survive reset; only the status bits are cleared
  always_ff @(posedge clk) begin
    if (lw_en) begin
      tags[idx] <= lw_tag;
      data[idx] <= lw_line;
    end else if (ww_en) begin
      data[idx][ww_off*WORD_W +: WORD_W] <= ww_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (lw_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (ww_en) begin
      dirty[idx] <= 1'b1;
    end else if (dirty_clr) begin
      dirty[idx] <= 1'b0;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally; a miss stalls the core, writes back a dirty
// victim, fills the line from main memory, then the access retries and hits.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   re, we, addr, wr_data      CPU request (re & we is handled as a write)
//   rd_data, stall             CPU load data and freeze
//   mem_re, mem_we, mem_addr   registered line request to main memory
//   mem_wr_line, mem_rd_line   victim / fill line, mem_rdy completion pulse
//   miss_cnt                   wrapping miss counter
module dcache_ctrl import dcache_pkg::*; #(
  parameter int INDEX_BITS = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            re,
  input  logic                            we,
  input  logic [ADDR_W-1:0]               addr,
  input  logic [WORD_W-1:0]               wr_data,
  output logic [WORD_W-1:0]               rd_data,
  output logic                            stall,
  output logic                            mem_re,
  output logic                            mem_we,
  output logic [ADDR_W-OFFSET_BITS-1:0]   mem_addr,
  output logic [LINE_W-1:0]               mem_wr_line,
  input  logic [LINE_W-1:0]               mem_rd_line,
  input  logic                            mem_rdy,
  output logic [15:0]                     miss_cnt
);
  localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int LADDR_W  = ADDR_W - OFFSET_BITS;

  state_t                state, state_nxt;
  logic [LADDR_W-1:0]    miss_laddr;
  logic                  req, hit, miss, victim_dirty;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag, arr_tag;
  logic                  arr_valid, arr_dirty;
  logic [LINE_W-1:0]     arr_line;
  logic                  ww_en, lw_en, dirty_clr;

  assign req = re | we;
  assign tag = addr[ADDR_W-1 -: TAG_BITS];
  // once a miss is in flight the array follows the latched line, not the CPU
  assign idx = (state == IDLE) ? addr[OFFSET_BITS +: INDEX_BITS]
                               : miss_laddr[INDEX_BITS-1:0];

  assign hit          = arr_valid && (arr_tag == tag);
  assign miss         = (state == IDLE) && req && !hit;
  assign victim_dirty = arr_valid && arr_dirty;
  assign stall        = (state != IDLE) || (req && !hit);
  assign rd_data      = line_word(arr_line, addr[OFFSET_BITS-1:0]);

  assign ww_en     = (state == IDLE) && we && hit;
  assign lw_en     = (state == ALLOCATE) && mem_rdy;
  assign dirty_clr = (state == WRITEBACK) && mem_rdy;

  dcache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .rd_tag    (arr_tag),
    .rd_valid  (arr_valid),
    .rd_dirty  (arr_dirty),
    .rd_line   (arr_line),
    .ww_en     (ww_en),
    .ww_off    (addr[OFFSET_BITS-1:0]),
    .ww_data   (wr_data),
    .lw_en     (lw_en),
    .lw_tag    (miss_laddr[LADDR_W-1 -: TAG_BITS]),
    .lw_line   (mem_rd_line),
    .dirty_clr (dirty_clr)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (miss) state_nxt = victim_dirty ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_rdy) state_nxt = ALLOCATE;
      ALLOCATE:  if (mem_rdy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      miss_laddr  <= '0;
      miss_cnt    <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_line <= '0;
    end else begin
      state  <= state_nxt;
      // memory strobes are pure functions of the registered state
      mem_re <= (state_nxt == ALLOCATE);
      mem_we <= (state_nxt == WRITEBACK);
      if (miss) begin
        miss_laddr <= addr[ADDR_W-1:OFFSET_BITS];
        miss_cnt   <= miss_cnt + 16'd1;
        if (victim_dirty) begin
          mem_addr    <= {arr_tag, idx};
          mem_wr_line <= arr_line;
        end else begin
          mem_addr <= addr[ADDR_W-1:OFFSET_BITS];
        end
      end else if (dirty_clr) begin
        mem_addr <= miss_laddr;
      end
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        re = 1'b0, we = 1'b0, mem_rdy = 1'b0;
  logic [15:0] addr = '0, wr_data = '0;
  logic [15:0] rd_data, miss_cnt;
  logic        stall, mem_re, mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wr_line, mem_rd_line = '0;

  int n_tests = 0, n_fail = 0;

  // behavioural cache + memory model, indexed by line number
  logic [63:0] m_data  [64];
  logic [7:0]  m_tag   [64];
  bit          m_valid [64];
  bit          m_dirty [64];
  logic [63:0] mem [logic [13:0]];
  logic [15:0] m_cnt = '0;

  always #5 clk = ~clk;

  dcache_ctrl #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .stall(stall), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line),
    .mem_rdy(mem_rdy), .miss_cnt(miss_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get_mem(input logic [13:0] la);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom};
    return mem[la];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_cnt = '0;
  endtask

  // One CPU access, starting and ending at posedge+1. lat = idle cycles before
  // mem_rdy; drop_at = fill cycle at which the CPU withdraws (-1 = never).
  task automatic access(input bit r, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input int lat, input int drop_at);
    logic [5:0]  ix = a[7:2];
    logic [7:0]  tg = a[15:8];
    logic [13:0] la = a[15:2];
    logic [13:0] va;
    logic [63:0] ln;
    bit h;
    re = r; we = w; addr = a; wr_data = d;
    h = m_valid[ix] && (m_tag[ix] == tg);
    @(negedge clk);
    chk("req_stall", stall, !h);
    if (!h) begin
      m_cnt++;
      @(posedge clk); #1;
      if (m_valid[ix] && m_dirty[ix]) begin
        va = {m_tag[ix], ix};
        for (int k = 0; k <= lat; k++) begin
          @(negedge clk);
          chk("wb_we", mem_we, 1);
          chk("wb_re", mem_re, 0);
          chk("wb_addr", mem_addr, va);
          chk("wb_line", mem_wr_line, m_data[ix]);
          if (k == lat) mem_rdy = 1'b1;
          @(posedge clk); #1;
          mem_rdy = 1'b0;
        end
        mem[va] = m_data[ix];
        m_dirty[ix] = 1'b0;
      end
      ln = get_mem(la);
      for (int k = 0; k <= lat; k++) begin
        if (k == drop_at) begin re = 1'b0; we = 1'b0; end
        @(negedge clk);
        chk("fill_re", mem_re, 1);
        chk("fill_we", mem_we, 0);
        chk("fill_addr", mem_addr, la);
        chk("fill_stall", stall, 1);
        if (k == lat) begin mem_rd_line = ln; mem_rdy = 1'b1; end
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        mem_rd_line = {$urandom, $urandom};
      end
      m_tag[ix] = tg; m_data[ix] = ln; m_valid[ix] = 1'b1; m_dirty[ix] = 1'b0;
      @(negedge clk);
      chk("retry_stall", stall, 0);
    end
    if (re || we) begin
      if (re) chk("rd_data", rd_data, m_data[ix][a[1:0]*16 +: 16]);
      chk("hit_mem_re", mem_re, 0);
      chk("hit_mem_we", mem_we, 0);
      @(posedge clk); #1;
      if (we) begin
        m_data[ix][a[1:0]*16 +: 16] = d;
        m_dirty[ix] = 1'b1;
      end
    end else begin
      @(posedge clk); #1;
    end
    chk("miss_cnt", miss_cnt, m_cnt);
    re = 1'b0; we = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wr_line", mem_wr_line, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed walk through the documented scenarios
    mem[14'h041] = 64'hDDDD_CCCC_BBBB_AAAA;
    access(1, 0, 16'h0104, 16'h0, 2, -1);
    chk("tp_cnt1", miss_cnt, 16'd1);
    access(1, 0, 16'h0105, 16'h0, 0, -1);
    access(0, 1, 16'h0106, 16'h1234, 0, -1);
    access(1, 0, 16'h0106, 16'h0, 0, -1);
    access(1, 0, 16'h0204, 16'h0, 1, -1);
    chk("tp_wb_line", mem_wr_line, 64'hDDDD_1234_BBBB_AAAA);
    chk("tp_mem_0x041", mem[14'h041], 64'hDDDD_1234_BBBB_AAAA);
    chk("tp_cnt2", miss_cnt, 16'd2);
    access(1, 0, 16'h0404, 16'h0, 10, 4);
    access(1, 0, 16'h0404, 16'h0, 0, -1);

    // reset while the fill for 0x0304 is outstanding
    re = 1'b1; addr = 16'h0304;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_mem_re", mem_re, 1);
    #2 rst_n = 1'b0; re = 1'b0;
    #1;
    chk("midrst_mem_re", mem_re, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_cnt", miss_cnt, 0);
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    access(1, 0, 16'h0105, 16'h0, 1, -1);
    chk("post_rst_cnt", miss_cnt, 16'd1);

    // random traffic over 4 tags x 4 indices to force hits, conflicts, dirty evictions
    for (int n = 0; n < 250; n++) begin
      logic [15:0] a;
      int op, lat, drop;
      a = {6'b0, 2'($urandom_range(0, 3)), 4'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 3);
      lat = $urandom_range(0, 3);
      drop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat) : -1;
      access(op < 2, op >= 2, a, 16'($urandom), lat, drop);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller for the CPU's MEM-stage memory port; the responder side of the core's memRd/memWr data interface.
- Services hits combinationally with zero stall.
- On a miss, asserts stall, writes back a dirty victim line, fills the new line from a multi-cycle line-wide main memory, then completes the access.
- Sits between the MEM stage and main memory; the core freezes its pipeline on stall.

Parameters:
- INDEX_BITS, 6, number of index bits (2^INDEX_BITS lines).
- Fixed by the shared defines, not parameters: word 16 bits; line 4 words (64 bits); offset addr[1:0]; index addr[INDEX_BITS+1:2]; tag addr[15:INDEX_BITS+2].

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- re  in  1  CPU read request (the memRd level).
- we  in  1  CPU write request (the memWr level).
- addr  in  16  CPU word address.
- wr_data  in  16  CPU store data.
- rd_data  out  16  CPU load data, combinational, valid when re & ~stall.
- stall  out  1  CPU must hold its request and freeze.
- mem_re  out  1  line read request to main memory.
- mem_we  out  1  line write request to main memory.
- mem_addr  out  14  line address (word address >> 2).
- mem_wr_line  out  64  victim line; word k occupies bits [16k+15:16k].
- mem_rd_line  in  64  fill line, same layout, valid when mem_rdy.
- mem_rdy  in  1  one-cycle completion pulse for the current mem_re/mem_we.
- miss_cnt  out  16  count of misses since reset, wraps at 0xFFFF.

Behaviour:
- Reset (async, rst_n low): state = IDLE; all valid and dirty bits = 0; miss_cnt = 0; mem_re = mem_we = 0; stall = 0; mem_addr = 0; mem_wr_line = 0.
- Reset does not clear tag or data arrays.
- Reset mid-transaction aborts it immediately; no line is installed.
- hit = valid[index] & (tag[index] == addr tag). req = re | we.
- State IDLE:
  - req & hit: stall = 0. A read drives the selected word on rd_data in the same cycle. A write updates that word and sets dirty at the clock edge. No memory traffic.
  - req & ~hit: stall = 1 combinationally in the same cycle; miss_cnt increments at the edge.
  - On that miss, next state = WRITEBACK if valid & dirty, else ALLOCATE.
- State WRITEBACK:
  - mem_we = 1; mem_addr = {victim tag, index}; mem_wr_line = victim line; all held stable until mem_rdy.
  - On mem_rdy: clear dirty, go to ALLOCATE.
- State ALLOCATE:
  - mem_re = 1; mem_addr = addr[15:2] (captured at miss entry); held until mem_rdy.
  - On mem_rdy: install mem_rd_line, tag, valid = 1, dirty = 0; go to IDLE.
- Retry: in IDLE the request is re-evaluated and now hits; the miss costs writeback + fill + 1 cycle.
- stall = (state != IDLE) | (req & ~hit).
- mem_re and mem_we are never high together. Each is registered, high only in its own state.
- The miss address is latched at miss entry. If the CPU drops or changes its request mid-miss, the fill still completes into the latched line and the FSM returns to IDLE.
- re & we together is illegal: treated as a write; rd_data shows the pre-write word.
- mem_rdy in IDLE is ignored.
- miss_cnt wraps from 0xFFFF to 0x0000.

Decomposition:
- The shared defines include holds:
  - state encodings: IDLE = 2'b00, WRITEBACK = 2'b01, ALLOCATE = 2'b10;
  - WORD_W = 16, LINE_W = 64, OFFSET_BITS = 2.
- One sub-module, dcache_array:
  - tag, valid, dirty and data storage;
  - asynchronous read, synchronous write, word-write and line-write ports;
  - async clear of valid and dirty.
- dcache_ctrl holds the FSM, miss latch, counter and muxing.

Test Plan:
- After reset, read 0x0104, memory answers on cycle 3 with 0xDDDD_CCCC_BBBB_AAAA -> stall = 1, mem_re = 1, mem_addr = 0x041; next cycle rd_data = 0xAAAA, stall = 0; miss_cnt = 1.
- Read 0x0105 immediately after -> hit, stall = 0 in the same cycle, rd_data = 0xBBBB, no mem_re.
- Write 0x0106 with 0x1234 -> no memory traffic; a following read of 0x0106 returns 0x1234.
- Read 0x0204 (same index, tag 0x02) -> mem_we with mem_addr = 0x041 and mem_wr_line = 0xDDDD_1234_BBBB_AAAA; then mem_re with mem_addr = 0x081; miss_cnt = 2.
- Hold mem_rdy low for 10 cycles in ALLOCATE, and drop re at cycle 4 -> mem_re and mem_addr stay stable; the line is installed on mem_rdy; a later read hits.
- Pulse rst_n low mid-ALLOCATE -> mem_re and stall drop immediately; a later read of 0x0105 misses; miss_cnt restarts at 1.
